// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional feature: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;
   localparam int NUM_WR_DEF = 2;
   localparam int CNT_W_DEF  = 16;

   // Address of the architectural zero register.
   localparam int ZERO_REG_ADDR = 0;

   // Low bit index of slice idx in a packed vector of w-bit fields.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/regfile_bypass_sel.sv
// Per-read-port write-before-read select: newest same-edge write data
// wins over the stored entry; highest write-port index has priority.
// With REGFILE_ZERO_REG_EN defined, reads of the zero register return 0.
module regfile_bypass_sel
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_WR = NUM_WR_DEF
) (
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0]        mem_data,
   output logic [DATA_W-1:0]        sel_data
);

   // Ascending scan so a matching higher-index port overrides lower ones.
   always_comb begin
      sel_data = mem_data;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == rd_addr)) begin
            sel_data = wr_data[slice_lo(p, DATA_W) +: DATA_W];
         end
      end
`ifdef REGFILE_ZERO_REG_EN
      if (rd_addr == ADDR_W'(ZERO_REG_ADDR)) begin
         sel_data = '0;
      end
`endif
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD registered read ports with
// write-before-read bypass and stall hold, up to two write ports (port 1
// wins on same-address writes), and a saturating write-collision counter.
// Optional feature: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF,
   parameter int NUM_WR = NUM_WR_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   output logic                     wr_collision,
   output logic [CNT_W-1:0]         collision_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [NUM_WR-1:0] wr_keep;
   logic [DATA_W-1:0] mem_rd   [NUM_RD];
   logic [DATA_W-1:0] byp_data [NUM_RD];

   // Effective write enables; zero-register writes are squashed here so they
   // neither update storage nor feed the read bypass.
   always_comb begin
      wr_keep = wr_en;
`ifdef REGFILE_ZERO_REG_EN
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(ZERO_REG_ADDR)) begin
            wr_keep[p] = 1'b0;
         end
      end
`endif
   end

   // Storage update; the ascending loop lets port 1 overwrite port 0 on a clash.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_keep[p]) begin
               mem[wr_addr[slice_lo(p, ADDR_W) +: ADDR_W]] <= wr_data[slice_lo(p, DATA_W) +: DATA_W];
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      assign mem_rd[r] = mem[rd_addr[r*ADDR_W +: ADDR_W]];

      regfile_bypass_sel #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_byp (
         .rd_addr  (rd_addr[r*ADDR_W +: ADDR_W]),
         .wr_en    (wr_keep),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .mem_data (mem_rd[r]),
         .sel_data (byp_data[r])
      );
   end

   // Registered read ports; a deasserted rd_en holds the previous data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= '0;
      end else begin
         rd_valid <= rd_en;
         for (int unsigned r = 0; r < NUM_RD; r++) begin
            if (rd_en[r]) begin
               rd_data[slice_lo(r, DATA_W) +: DATA_W] <= byp_data[r];
            end
         end
      end
   end

   if (NUM_WR == 2) begin : g_coll
      logic coll_now;

      // Collisions are counted on raw enables, so zero-register clashes count too.
      always_comb begin
         coll_now = wr_en[0] && wr_en[1] &&
                    (wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W]);
      end

      // One-cycle collision pulse and saturating event counter.
      always_ff @(posedge clk) begin
         if (rst) begin
            wr_collision  <= 1'b0;
            collision_cnt <= '0;
         end else begin
            wr_collision <= coll_now;
            if (coll_now && (collision_cnt != '1)) begin
               collision_cnt <= collision_cnt + CNT_W'(1);
            end
         end
      end
   end else begin : g_no_coll
      assign wr_collision  = 1'b0;
      assign collision_cnt = '0;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, a counter
// saturation sequence on a narrow-counter instance, and randomized traffic
// against an array-based reference model. Honours REGFILE_ZERO_REG_EN.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_valid;
   logic        wr_collision;
   logic [15:0] collision_cnt;

   logic        s_rst;
   logic [1:0]  s_wr_en;
   logic [9:0]  s_wr_addr;
   logic [63:0] s_wr_data;
   logic [1:0]  s_rd_en;
   logic [9:0]  s_rd_addr;
   logic [63:0] s_rd_data;
   logic [1:0]  s_rd_valid;
   logic        s_wr_collision;
   logic [1:0]  s_collision_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .CNT_W (16)
   ) u_dut (
      .clk (clk), .rst (rst),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
      .rd_valid (rd_valid), .wr_collision (wr_collision),
      .collision_cnt (collision_cnt)
   );

   regfile_mp #(
      .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .CNT_W (2)
   ) u_sat (
      .clk (clk), .rst (s_rst),
      .wr_en (s_wr_en), .wr_addr (s_wr_addr), .wr_data (s_wr_data),
      .rd_en (s_rd_en), .rd_addr (s_rd_addr), .rd_data (s_rd_data),
      .rd_valid (s_rd_valid), .wr_collision (s_wr_collision),
      .collision_cnt (s_collision_cnt)
   );

`ifdef REGFILE_ZERO_REG_EN
   localparam logic [31:0] ZV  = 32'h0;
   localparam logic [31:0] ZV2 = 32'h0;
`else
   localparam logic [31:0] ZV  = 32'hFFFF_FFFF;
   localparam logic [31:0] ZV2 = 32'h2;
`endif

   typedef struct {
      logic        rst;
      logic [1:0]  wr_en;
      logic [9:0]  wr_addr;
      logic [63:0] wr_data;
      logic [1:0]  rd_en;
      logic [9:0]  rd_addr;
      logic [63:0] exp_data;
      logic [1:0]  exp_valid;
      logic        exp_coll;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [16];

   // Reference model state
   logic [31:0] m_mem [32];
   logic [31:0] m_rd  [2];
   logic [1:0]  m_valid;
   logic        m_coll;
   logic [15:0] m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [1:0] we, input logic [9:0] wa,
                               input logic [63:0] wd, input logic [1:0] re, input logic [9:0] ra,
                               input logic [63:0] ed, input logic [1:0] ev, input logic ec,
                               input logic [15:0] en);
      vec_t v;
      v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
      v.rd_en = re; v.rd_addr = ra; v.exp_data = ed; v.exp_valid = ev;
      v.exp_coll = ec; v.exp_cnt = en;
      return v;
   endfunction

   // Value of the register file after one clock edge, derived from the
   // architectural rules: apply writes in priority order, then read.
   task automatic model_step();
      logic coll;
      int unsigned a;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_mem[i] = '0;
         m_rd[0] = '0; m_rd[1] = '0;
         m_valid = '0; m_coll = 1'b0; m_cnt = '0;
      end else begin
         coll = (wr_en == 2'b11) && (wr_addr[4:0] == wr_addr[9:5]);
         for (int p = 0; p < 2; p++) begin
            a = wr_addr[p*5 +: 5];
`ifdef REGFILE_ZERO_REG_EN
            if (wr_en[p] && a != 0) m_mem[a] = wr_data[p*32 +: 32];
`else
            if (wr_en[p]) m_mem[a] = wr_data[p*32 +: 32];
`endif
         end
         for (int r = 0; r < 2; r++) begin
            if (rd_en[r]) m_rd[r] = m_mem[rd_addr[r*5 +: 5]];
         end
         m_valid = rd_en;
         m_coll = coll;
         if (coll && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
      s_rst = 1'b1; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0; s_rd_en = '0; s_rd_addr = '0;

      // Counter saturation on the 2-bit counter instance
      @(posedge clk); #1;
      check("sat reset cnt", {62'd0, s_collision_cnt}, 64'd0);
      s_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         s_wr_en = 2'b11;
         s_wr_addr = {5'(k + 1), 5'(k + 1)};
         s_wr_data = {32'(k), 32'(k + 100)};
         @(posedge clk); #1;
         check($sformatf("sat coll %0d", k), {63'd0, s_wr_collision}, 64'd1);
         check($sformatf("sat cnt %0d", k), {62'd0, s_collision_cnt}, (k < 2) ? 64'(k + 1) : 64'd3);
      end
      s_wr_addr = {5'd1, 5'd2};
      @(posedge clk); #1;
      check("sat no coll", {63'd0, s_wr_collision}, 64'd0);
      check("sat hold cnt", {62'd0, s_collision_cnt}, 64'd3);
      s_wr_en = '0;

      // Directed vectors
      vecs[0]  = mk(1, 2'b11, {5'd3, 5'd3}, {32'h1, 32'h2}, 2'b11, {5'd3, 5'd3}, 64'h0, 2'b00, 0, 0);
      vecs[1]  = mk(1, 2'b00, 10'd0, 64'h0, 2'b11, {5'd3, 5'd3}, 64'h0, 2'b00, 0, 0);
      vecs[2]  = mk(0, 2'b00, 10'd0, 64'h0, 2'b11, {5'd7, 5'd3}, 64'h0, 2'b11, 0, 0);
      vecs[3]  = mk(0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 2'b01, {5'd0, 5'd5},
                    {32'h0, 32'hDEADBEEF}, 2'b01, 0, 0);
      vecs[4]  = mk(0, 2'b00, 10'd0, 64'h0, 2'b11, {5'd5, 5'd5},
                    {32'hDEADBEEF, 32'hDEADBEEF}, 2'b11, 0, 0);
      vecs[5]  = mk(0, 2'b11, {5'd9, 5'd9}, {32'h22, 32'h11}, 2'b01, {5'd0, 5'd9},
                    {32'hDEADBEEF, 32'h22}, 2'b01, 1, 1);
      vecs[6]  = mk(0, 2'b00, 10'd0, 64'h0, 2'b10, {5'd9, 5'd0}, {32'h22, 32'h22}, 2'b10, 0, 1);
      vecs[7]  = mk(0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'hA5}, 2'b01, {5'd0, 5'd4},
                    {32'h22, 32'hA5}, 2'b01, 0, 1);
      vecs[8]  = mk(0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h5A}, 2'b00, {5'd4, 5'd4},
                    {32'h22, 32'hA5}, 2'b00, 0, 1);
      vecs[9]  = mk(0, 2'b00, 10'd0, 64'h0, 2'b01, {5'd0, 5'd4}, {32'h22, 32'h5A}, 2'b01, 0, 1);
      vecs[10] = mk(0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFF_FFFF}, 2'b01, {5'd0, 5'd0},
                    {32'h22, ZV}, 2'b01, 0, 1);
      vecs[11] = mk(0, 2'b00, 10'd0, 64'h0, 2'b10, {5'd0, 5'd0}, {ZV, ZV}, 2'b10, 0, 1);
      vecs[12] = mk(0, 2'b11, {5'd0, 5'd0}, {32'h2, 32'h1}, 2'b00, 10'd0, {ZV, ZV}, 2'b00, 1, 2);
      vecs[13] = mk(0, 2'b00, 10'd0, 64'h0, 2'b11, {5'd0, 5'd0}, {ZV2, ZV2}, 2'b11, 0, 2);
      vecs[14] = mk(1, 2'b11, {5'd6, 5'd6}, {32'h7, 32'h8}, 2'b11, {5'd6, 5'd5}, 64'h0, 2'b00, 0, 0);
      vecs[15] = mk(0, 2'b00, 10'd0, 64'h0, 2'b11, {5'd6, 5'd5}, 64'h0, 2'b11, 0, 0);

      for (int i = 0; i < 16; i++) begin
         rst = vecs[i].rst; wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
         wr_data = vecs[i].wr_data; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
         @(posedge clk); #1;
         check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
         check($sformatf("vec%0d rd_valid", i), {62'd0, rd_valid}, {62'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d wr_collision", i), {63'd0, wr_collision}, {63'd0, vecs[i].exp_coll});
         check($sformatf("vec%0d collision_cnt", i), {48'd0, collision_cnt}, {48'd0, vecs[i].exp_cnt});
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         rst     = (i == 0) || ($urandom_range(0, 59) == 0);
         wr_en   = 2'($urandom_range(0, 3));
         wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_data = {32'($urandom), 32'($urandom)};
         rd_en   = 2'($urandom_range(0, 3));
         rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         @(posedge clk);
         model_step();
         #1;
         check($sformatf("rnd%0d rd_data", i), rd_data, {m_rd[1], m_rd[0]});
         check($sformatf("rnd%0d rd_valid", i), {62'd0, rd_valid}, {62'd0, m_valid});
         check($sformatf("rnd%0d wr_collision", i), {63'd0, wr_collision}, {63'd0, m_coll});
         check($sformatf("rnd%0d collision_cnt", i), {48'd0, collision_cnt}, {48'd0, m_cnt});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
